// File: rtl/wb_to_drp_mux.sv
// Classic Wishbone target fanned out to NCH DRP ports: one access in flight,
// per-access drprdy timeout, out-of-range channel rejection, saturating timeout counter.
//
// state | meaning
// IDLE  | waiting for cyc&stb; latches address/data/channel
// ISSUE | single-cycle drpen/drpwe pulse, timer loaded
// WAIT  | waiting for drprdy of the selected channel or timer expiry
// ACK   | ack pulse (suppressed if master dropped cyc)
// ERR   | err pulse for bad channel or timeout
module wb_to_drp_mux #(
  parameter int NCH     = 2,
  parameter int DRP_AW  = 10,
  parameter int DRP_DW  = 16,
  parameter int WB_AW   = 13,
  parameter int TIMEOUT = 1024
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [WB_AW-1:0]        wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [NCH-1:0]          drpen,
  output logic                    drpwe,
  output logic [DRP_AW-1:0]       drpaddr,
  output logic [DRP_DW-1:0]       drpdi,
  input  logic [NCH-1:0]          drprdy,
  input  logic [NCH*DRP_DW-1:0]   drpdo,
  output logic [15:0]             timeout_count
);

  localparam int CB = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_ERR
  } state_t;

  state_t              state_q;
  logic [CB-1:0]       ch_q;
  logic [TW-1:0]       tmo_q;
  logic [NCH-1:0]      drpen_q;
  logic                drpwe_q;
  logic [DRP_AW-1:0]   drpaddr_q;
  logic [DRP_DW-1:0]   drpdi_q;
  logic [31:0]         dat_q;
  logic                ack_q;
  logic                err_q;
  logic [15:0]         tcnt_q;

  logic [CB-1:0]       ch_d;
  logic [31:0]         ch_ext_d;
  logic                ch_ok_d;
  logic [NCH-1:0]      en_d;
  logic                sel_rdy_d;
  logic [DRP_DW-1:0]   sel_do_d;
  logic [31:0]         rd_d;

  assign ch_d     = wb_adr_i[2+DRP_AW +: CB];
  assign ch_ext_d = 32'(ch_d);
  assign ch_ok_d  = ch_ext_d < 32'(NCH);

  // Channel muxing is done by compare loops so that a channel field wider
  // than NCH never indexes past the drprdy/drpdo vectors.
  always_comb begin
    en_d      = '0;
    sel_rdy_d = 1'b0;
    sel_do_d  = '0;
    rd_d      = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_d == CB'(c)) begin
        en_d[c] = 1'b1;
      end
      if (ch_q == CB'(c)) begin
        sel_rdy_d = drprdy[c];
        sel_do_d  = drpdo[c*DRP_DW +: DRP_DW];
      end
    end
    rd_d[DRP_DW-1:0] = sel_do_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      tmo_q     <= '0;
      drpen_q   <= '0;
      drpwe_q   <= 1'b0;
      drpaddr_q <= '0;
      drpdi_q   <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      drpen_q <= '0;
      drpwe_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            ch_q      <= ch_d;
            drpaddr_q <= wb_adr_i[2 +: DRP_AW];
            drpdi_q   <= wb_dat_i[DRP_DW-1:0];
            if (ch_ok_d) begin
              drpen_q <= en_d;
              drpwe_q <= wb_we_i;
              state_q <= S_ISSUE;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_ISSUE: begin
          tmo_q   <= TMO_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A DRP access cannot be aborted; only the termination is gated by cyc.
          if (sel_rdy_d) begin
            dat_q   <= rd_d;
            ack_q   <= wb_cyc_i;
            state_q <= S_ACK;
          end else if (tmo_q == '0) begin
            dat_q   <= '1;
            err_q   <= wb_cyc_i;
            if (tcnt_q != 16'hFFFF) begin
              tcnt_q <= tcnt_q + 16'd1;
            end
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        S_ACK:   state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_dat_o      = dat_q;
  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign wb_rty_o      = 1'b0;
  assign drpen         = drpen_q;
  assign drpwe         = drpwe_q;
  assign drpaddr       = drpaddr_q;
  assign drpdi         = drpdi_q;
  assign timeout_count = tcnt_q;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i, wb_dat_i};

endmodule

// File: tb/tb_wb_to_drp_mux.sv
// Bench for wb_to_drp_mux: an event-timeline reference model checked every cycle,
// plus directed transactions with hand-computed latencies and data.
module tb_wb_to_drp_mux;
  localparam int NCH = 3, DRP_AW = 10, DRP_DW = 16, WB_AW = 14, TIMEOUT = 8;

  logic clk = 1'b0, rst_n = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [WB_AW-1:0] adr = '0;
  logic [31:0] dat_i = '0, dat_o;
  logic ack, err, rty, drpwe;
  logic [NCH-1:0] drpen, drprdy = '0;
  logic [DRP_AW-1:0] drpaddr;
  logic [DRP_DW-1:0] drpdi;
  logic [NCH*DRP_DW-1:0] drpdo = '0;
  logic [15:0] tcount;
  int tests = 0, fails = 0, ncyc = 0;

  wb_to_drp_mux #(.NCH(NCH), .DRP_AW(DRP_AW), .DRP_DW(DRP_DW), .WB_AW(WB_AW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rty_o(rty), .drpen(drpen), .drpwe(drpwe), .drpaddr(drpaddr), .drpdi(drpdi),
    .drprdy(drprdy), .drpdo(drpdo), .timeout_count(tcount));

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the age of the outstanding access in clock edges
  bit m_busy = 0;
  int m_age = 0, m_hold = 0, m_ch = 0;
  logic [NCH-1:0] x_en = '0;
  logic x_we = 0, x_ack = 0, x_err = 0;
  logic [DRP_AW-1:0] x_addr = '0;
  logic [DRP_DW-1:0] x_di = '0;
  logic [31:0] x_dat = '0;
  logic [15:0] x_tc = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; m_age = 0;
      x_en = '0; x_we = 0; x_ack = 0; x_err = 0;
      x_addr = '0; x_di = '0; x_dat = '0; x_tc = '0;
    end else begin
      x_en = '0; x_we = 0; x_ack = 0; x_err = 0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (m_busy) begin
        m_age++;
        if (m_age >= 2 && drprdy[m_ch]) begin
          x_ack = cyc; x_dat = 32'(drpdo[m_ch*DRP_DW +: DRP_DW]);
          m_busy = 0; m_hold = 1;
        end else if (m_age == TIMEOUT + 1) begin
          x_err = cyc; x_dat = 32'hFFFF_FFFF;
          if (x_tc != 16'hFFFF) x_tc = x_tc + 16'd1;
          m_busy = 0; m_hold = 1;
        end
      end else if (cyc && stb) begin
        m_ch = int'(adr[13:12]);
        x_addr = adr[2 +: DRP_AW];
        x_di = dat_i[DRP_DW-1:0];
        if (m_ch >= NCH) begin
          x_err = 1; m_hold = 1;
        end else begin
          x_en = NCH'(1 << m_ch); x_we = we; m_busy = 1; m_age = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_drpen", 32'(drpen), 32'(x_en));
    chk("m_drpwe", 32'(drpwe), 32'(x_we));
    chk("m_drpaddr", 32'(drpaddr), 32'(x_addr));
    chk("m_drpdi", 32'(drpdi), 32'(x_di));
    chk("m_ack", 32'(ack), 32'(x_ack));
    chk("m_err", 32'(err), 32'(x_err));
    chk("m_dat", dat_o, x_dat);
    chk("m_tcount", 32'(tcount), 32'(x_tc));
    chk("m_rty", 32'(rty), 32'd0);
  end

  // One Wishbone access with a DRP responder; kind: 0 none, 1 ack, 2 err
  task automatic xfer(input logic [WB_AW-1:0] a, input logic w, input logic [31:0] d,
                      input int dly, input logic [15:0] rd, input int abort_at, input bit noise,
                      output int req_e, output int pen, output int term, output int kind,
                      output logic [NCH-1:0] en_seen, output logic we_seen, output logic [31:0] dat_seen);
    int ch;
    bit aborted;
    ch = int'(a[13:12]);
    pen = -1; term = -1; kind = 0; aborted = 0;
    en_seen = '0; we_seen = 0; dat_seen = '0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; req_e = ncyc + 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drpen != 0 && pen < 0) begin pen = ncyc; en_seen = drpen; we_seen = drpwe; end
      if ((ack || err) && kind == 0) begin kind = ack ? 1 : 2; term = ncyc; dat_seen = dat_o; end
      @(posedge clk); #1;
      drprdy = '0;
      if (kind != 0) begin cyc = 0; stb = 0; we = 0; break; end
      if (pen >= 0 && abort_at >= 0 && ncyc == pen + abort_at) begin cyc = 0; stb = 0; aborted = 1; end
      if (aborted && ncyc >= pen + dly + 3) break;
      if (pen >= 0 && dly >= 0 && ncyc == pen + dly && ch < NCH) begin
        drprdy[ch] = 1'b1; drpdo[ch*DRP_DW +: DRP_DW] = rd;
      end
      if (noise && pen >= 0) begin
        drprdy[(ch+1)%NCH] = 1'b1; drpdo[((ch+1)%NCH)*DRP_DW +: DRP_DW] = 16'h0BAD;
      end
    end
    if (kind == 0 && !aborted) begin
      tests++; fails++;
      $display("FAIL xfer_budget: adr %h got no termination, required ack or err", a);
    end
  endtask

  int r, p, t, k;
  logic [NCH-1:0] e;
  logic ws;
  logic [31:0] ds;

  initial begin
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    #1;
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_tc", 32'(tcount), 32'd0);
    chk("rst_drpen", 32'(drpen), 32'd0);

    // read ch1, drpaddr 2, ready 3 cycles after drpen
    xfer(14'h1008, 0, 32'h0, 3, 16'hBEEF, -1, 0, r, p, t, k, e, ws, ds);
    chk("rd_pen_lat", 32'(p - r), 32'd0);
    chk("rd_en", 32'(e), 32'b010);
    chk("rd_we", 32'(ws), 32'd0);
    chk("rd_kind", 32'(k), 32'd1);
    chk("rd_lat", 32'(t - p), 32'd4);
    chk("rd_dat", ds, 32'h0000_BEEF);
    chk("rd_addr", 32'(drpaddr), 32'd2);

    // write ch0, minimum latency
    xfer(14'h0010, 1, 32'h1234_5678, 1, 16'h0A0A, -1, 0, r, p, t, k, e, ws, ds);
    chk("wr_en", 32'(e), 32'b001);
    chk("wr_we", 32'(ws), 32'd1);
    chk("wr_kind", 32'(k), 32'd1);
    chk("wr_minlat", 32'(t - r), 32'd2);
    chk("wr_di", 32'(drpdi), 32'h5678);
    chk("wr_addr", 32'(drpaddr), 32'd4);

    // write ch2 top address, other channels' ready toggling
    xfer(14'h2FFC, 1, 32'hCAFE_F00D, 2, 16'h1111, -1, 1, r, p, t, k, e, ws, ds);
    chk("ch2_en", 32'(e), 32'b100);
    chk("ch2_lat", 32'(t - p), 32'd3);
    chk("ch2_dat", ds, 32'h0000_1111);
    chk("ch2_addr", 32'(drpaddr), 32'h3FF);
    chk("ch2_di", 32'(drpdi), 32'hF00D);

    // byte offset bits ignored
    xfer(14'h0007, 0, 32'h0, 1, 16'h00C3, -1, 0, r, p, t, k, e, ws, ds);
    chk("off_addr", 32'(drpaddr), 32'd1);
    chk("off_dat", ds, 32'h0000_00C3);

    // timeout, then stray ready
    xfer(14'h1020, 0, 32'h0, -1, 16'h0, -1, 0, r, p, t, k, e, ws, ds);
    chk("to_kind", 32'(k), 32'd2);
    chk("to_lat", 32'(t - p), 32'(TIMEOUT + 1));
    chk("to_dat", ds, 32'hFFFF_FFFF);
    chk("to_cnt", 32'(tcount), 32'd1);
    @(posedge clk); #1 drprdy[1] = 1;
    repeat (2) @(posedge clk);
    #1 drprdy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_dat", dat_o, 32'hFFFF_FFFF);
    chk("stray_cnt", 32'(tcount), 32'd1);

    // out-of-range channel 3
    xfer(14'h3000, 0, 32'h0, 1, 16'h0, -1, 0, r, p, t, k, e, ws, ds);
    chk("oor_kind", 32'(k), 32'd2);
    chk("oor_lat", 32'(t - r), 32'd0);
    chk("oor_noen", 32'(p), 32'hFFFF_FFFF);

    // cyc dropped in WAIT: no termination, next access normal
    xfer(14'h1004, 0, 32'h0, 4, 16'h7777, 2, 0, r, p, t, k, e, ws, ds);
    chk("abort_kind", 32'(k), 32'd0);
    xfer(14'h000C, 0, 32'h0, 2, 16'h4242, -1, 0, r, p, t, k, e, ws, ds);
    chk("post_abort_kind", 32'(k), 32'd1);
    chk("post_abort_dat", ds, 32'h0000_4242);

    // reset mid-WAIT
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = 0; adr = 14'h1010;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_dat", dat_o, 32'd0);
    chk("arst_tc", 32'(tcount), 32'd0);
    chk("arst_addr", 32'(drpaddr), 32'd0);
    chk("arst_ack", 32'({ack, err, drpwe}), 32'd0);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    xfer(14'h1014, 0, 32'h0, 1, 16'h5A5A, -1, 0, r, p, t, k, e, ws, ds);
    chk("post_rst_kind", 32'(k), 32'd1);
    chk("post_rst_dat", ds, 32'h0000_5A5A);
    chk("post_rst_addr", 32'(drpaddr), 32'd5);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion by 100us");
    $fatal(1, "watchdog");
  end
endmodule
